// File: rtl/alu_muldiv.sv
// alu_muldiv: registered EX-stage ALU with iterative radix-2 multiply/divide.
// Simple ops complete in one cycle. MULT/MULTU/DIV/DIVU run WIDTH iterations
// on operand magnitudes. Sign correction is applied in FIN, which then writes HI/LO.
//
// state | meaning
// IDLE  | waiting for start; simple ops computed here
// MUL   | one shift-add step per cycle on magnitudes
// DIV   | one restoring shift-subtract step per cycle on magnitudes
// FIN   | sign correction, HI/LO write, done pulse
`timescale 1ns/1ps
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic               neg_q, neg_d;     // negate product / quotient
  logic               rneg_q, rneg_d;   // negate remainder
  logic               dbz_q, dbz_d;     // current divide has b==0
  logic               is_div_q, is_div_d;
  logic               pend_q, pend_d;   // simple op accepted last cycle
  logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic               zero_q, zero_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic               dbzf_q, dbzf_d;

  logic [WIDTH-1:0]   alu_res, sum_ab, dif_ab, mag_a, mag_b, quo, rem;
  logic               alu_ovf, is_md, sgn, sa, sb, ge;
  logic [WIDTH:0]     mul_sum, div_tmp, div_dif;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;

  // Simple-op ALU and operand magnitude preparation.
  always_comb begin
    sum_ab  = a + b;
    dif_ab  = a - b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0010: begin
        alu_res = sum_ab;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        alu_res = dif_ab;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ab[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0011: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1100: alu_res = ~(a | b);
      default: alu_res = '0;
    endcase
    is_md = (op[3:2] == 2'b10);
    sgn   = ~op[0];
    sa    = sgn & a[WIDTH-1];
    sb    = sgn & b[WIDTH-1];
    mag_a = sa ? ({WIDTH{1'b0}} - a) : a;
    mag_b = sb ? ({WIDTH{1'b0}} - b) : b;
  end

  // Single iteration datapath for multiply and restoring divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_dif  = div_tmp - {1'b0, opnd_q};
    ge       = (div_tmp >= {1'b0, opnd_q});
    div_next = {(ge ? div_dif[WIDTH-1:0] : div_tmp[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
    prod     = neg_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
    quo      = neg_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem      = rneg_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the FSM and all output registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dbz_d    = dbz_q;
    is_div_d = is_div_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbzf_d   = dbzf_q;
    pend_d   = 1'b0;
    done_d   = pend_q;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          dbzf_d = 1'b0;
          if (is_md) begin
            is_div_d = op[1];
            neg_d    = sa ^ sb;
            rneg_d   = sa;
            dbz_d    = op[1] && (b == '0);
            cnt_d    = '0;
            if (op[1]) begin
              acc_d   = {{WIDTH{1'b0}}, mag_a};
              opnd_d  = mag_b;
              state_d = S_DIV;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, mag_b};
              opnd_d  = mag_a;
              state_d = S_MUL;
            end
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            pend_d   = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = (state_q == S_MUL) ? mul_next : div_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIN;
        end
      end
      default: begin
        if (is_div_q) begin
          lo_d   = dbz_q ? {WIDTH{1'b1}} : quo;
          hi_d   = rem;
          dbzf_d = dbz_q;
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
      is_div_q <= 1'b0;
      pend_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbzf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dbz_q    <= dbz_d;
      is_div_q <= is_div_d;
      pend_q   <= pend_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbzf_q   <= dbzf_d;
    end
  end

  assign result      = result_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbzf_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed testbench for alu_muldiv (WIDTH=32).
`timescale 1ns/1ps
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, cancel;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] result, hi, lo;
  logic         zero, overflow, busy, done, div_by_zero;

  int total = 0;
  int bad   = 0;
  int lat, cnt;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel), .op(op),
    .a(a), .b(b), .result(result), .zero(zero), .overflow(overflow),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges counted after the accepting edge until done is seen, bounded.
  task automatic wait_done(input int maxc, output int l);
    l = 0;
    do begin
      tick();
      l++;
    end while (done !== 1'b1 && l < maxc);
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done === 1'b1) c++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 4'b0; a = '0; b = '0;
    tick(); tick();
    chk("rst_result", result, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_flags", {zero, overflow, busy, done, div_by_zero}, 0);
    reset = 1'b0;

    // MULTU -2 x 3 (unsigned)
    go(4'b1001, 32'hFFFF_FFFE, 32'd3);
    chk("multu_busy", busy, 1);
    wait_done(40, lat);
    chk("multu_lat", lat, 33);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);
    chk("multu_busy_end", busy, 0);

    // Reset in the middle of MULT
    go(4'b1000, 32'hFFFF_FFFE, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy_done", {busy, done}, 0);
    count_done(40, cnt);
    chk("midrst_no_done", cnt, 0);

    // ADD overflow
    go(4'b0010, 32'h7FFF_FFFF, 32'd1);
    chk("add_done_early", done, 0);
    wait_done(5, lat);
    chk("add_lat", lat, 1);
    chk("add_res", result, 32'h8000_0000);
    chk("add_zo", {zero, overflow}, 2'b01);

    go(4'b0110, 32'd5, 32'd5);
    wait_done(5, lat);
    chk("sub_lat", lat, 1);
    chk("sub_res", result, 0);
    chk("sub_zo", {zero, overflow}, 2'b10);

    go(4'b0111, 32'hFFFF_FFFF, 32'd1);
    wait_done(5, lat);
    chk("slt_lat", lat, 1);
    chk("slt_res", {result, zero}, {32'd1, 1'b0});

    go(4'b0011, 32'hFFFF_FFFF, 32'd1);
    wait_done(5, lat);
    chk("sltu_lat", lat, 1);
    chk("sltu_res", {result, zero}, {32'd0, 1'b1});

    // Start held two cycles: two back-to-back simple ops
    op = 4'b0010; a = 32'd1; b = 32'd2; start = 1'b1;
    tick();
    chk("hold_res1", result, 3);
    a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0;
    chk("hold_res2", {result, done}, {32'd7, 1'b1});
    tick();
    chk("hold_done2", done, 1);
    tick();

    // cancel together with start in IDLE: ignored
    op = 4'b0010; a = 32'd5; b = 32'd5; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_res", result, 7);
    count_done(3, cnt);
    chk("cancel_start_nodone", {busy, cnt[7:0]}, 0);

    // Signed MULT, result unchanged by mul
    go(4'b1000, 32'hFFFF_FFFE, 32'd3);
    wait_done(40, lat);
    chk("mult_lat", lat, 33);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mult_res_kept", result, 7);

    go(4'b1010, 32'hFFFF_FFF9, 32'd2);
    wait_done(40, lat);
    chk("div_lat", lat, 33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_dbz", div_by_zero, 0);

    go(4'b1011, 32'd7, 32'd0);
    wait_done(40, lat);
    chk("divu0_lat", lat, 33);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd7);
    chk("divu0_flag", div_by_zero, 1);
    go(4'b0010, 32'd1, 32'd1);
    chk("dbz_cleared", {div_by_zero, result}, {1'b0, 32'd2});
    tick();

    go(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(40, lat);
    chk("divmn_lat", lat, 33);
    chk("divmn_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    chk("divmn_flag", div_by_zero, 0);

    // MULT with start re-pulsed while busy, cancel at step 15
    go(4'b1000, 32'd3, 32'd4);
    op = 4'b0010; a = 32'd9; b = 32'd9; start = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("cxl_busy_before", busy, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0; start = 1'b0;
    chk("cxl_busy", {busy, done}, 0);
    chk("cxl_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    chk("cxl_res_kept", result, 2);
    count_done(40, cnt);
    chk("cxl_no_done", cnt, 0);
    go(4'b1000, 32'd3, 32'd4);
    wait_done(40, lat);
    chk("mult34_lat", lat, 33);
    chk("mult34_hilo", {hi, lo}, 64'd12);
    tick();
    chk("done_pulse_one", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, sequential successor to the EX-stage ALU in the five-stage MIPS pipeline.
- Adds registered results, a start/busy/done handshake, unsigned compare, and iterative radix-2 multiply/divide writing HI/LO.
- Hazard unit stalls ID/EX while busy=1.
- MFHI/MFLO read the hi/lo ports directly.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, even).
- CNT_W, $clog2(WIDTH)+1, iteration-counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  sample op/a/b; accepted only when busy=0.
- cancel  input  1  pipeline flush; aborts an in-flight mul/div.
- op  input  4  operation code, encoded as listed under Behaviour.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt/imm).
- result  output  WIDTH  registered result of the last simple op.
- zero  output  1  registered: result==0.
- overflow  output  1  registered signed overflow for ADD/SUB; 0 otherwise.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  mul/div in progress.
- done  output  1  one-cycle pulse: operation complete, outputs valid.
- div_by_zero  output  1  registered; set by DIV/DIVU with b==0, cleared by the next accepted start.

Behaviour:
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0011 SLTU, 1100 NOR.
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU.
  - Any other code gives result=0.
- Reset: all outputs 0, including hi, lo, busy, done, div_by_zero; FSM goes to IDLE, counter 0.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE + start + simple op: compute, register result/zero/overflow, pulse done on the next cycle; stay IDLE. Latency 1.
  - IDLE + start + mul/div: latch operands into internal registers.
    - Signed ops latch magnitudes plus sign flags.
    - Go to MUL or DIV with counter=0; busy=1 from the next cycle.
  - MUL: one shift-add step per cycle, WIDTH steps. After step WIDTH-1, go to FIN.
  - DIV: one restoring shift-subtract step per cycle, WIDTH steps. After step WIDTH-1, go to FIN.
  - FIN: apply sign correction, write hi/lo, busy=0, done=1 for one cycle, return to IDLE.
  - Total latency: done asserted WIDTH+1 cycles after the start edge.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = 2*WIDTH-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed DIV: quotient truncates toward zero; remainder takes the dividend's sign.
  - Overflow rules as ADD/SUB standard two's-complement; never set for other ops.
  - result/zero/overflow are unchanged by mul/div ops.
- Boundary conditions:
  - start while busy=1: ignored; no state change.
  - start held high continuously: a new op is accepted each cycle busy=0.
  - Divide by zero: full latency still taken; hi=a (dividend), lo=all ones, div_by_zero=1; no hang.
  - Signed DIV of most-negative by -1: lo=most-negative, hi=0, no flag.
  - cancel during MUL/DIV: next state IDLE, busy=0, no done; hi/lo keep previous values.
  - cancel in IDLE or FIN: no effect; FIN still writes hi/lo and pulses done.
  - cancel together with start in IDLE: start is ignored.
  - reset has priority over everything, including mid-operation: hi/lo cleared, no done pulse.

Test Plan:
- Reset mid-MULT (cycle 10), then ADD 0x7FFFFFFF+1 -> after reset: hi=lo=0, busy=0, no done; ADD gives done 1 cycle later, result=0x80000000, overflow=1, zero=0.
- SUB 5-5; SLT 0xFFFFFFFF,1; SLTU 0xFFFFFFFF,1 -> results 0 (zero=1); 1; 0 (zero=1); each done 1 cycle after start.
- MULT 0xFFFFFFFE(-2) x 3 -> done 33 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV -7/2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIVU 7/0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1; next ADD clears div_by_zero.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0, latency 33.
- MULT 3x4 with start re-pulsed every cycle while busy, cancel at step 15 -> re-pulses ignored; cancel gives busy=0 next cycle, no done, hi/lo unchanged; new MULT 3x4 then gives lo=12, hi=0.
